// File: rtl/lcd_ui_pkg.sv
// Shared types for the keypad renderer: colours, cursor directions and key-code lookup.
package lcd_ui_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t RED    = 24'hFF0000;
  localparam rgb_t ORANGE = 24'hFFA500;
  localparam rgb_t GRAY   = 24'hBEBEBE;
  localparam rgb_t WHITE  = 24'hFFFFFF;
  localparam rgb_t BLACK  = 24'h000000;
  localparam rgb_t YELLOW = 24'hFFFF00;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col,
                                           input int cols);
    return 4'(row) * 4'(cols) + 4'(col);
  endfunction

  // Layout "123456789+0="; unused indices give 0 and render as blank buttons.
  function automatic logic [7:0] key_code(input logic [3:0] index);
    case (index)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8: key_code = 8'h31 + 8'(index);
      4'd9:                   key_code = 8'h2B;
      4'd10:                  key_code = 8'h30;
      4'd11:                  key_code = 8'h3D;
      default:                key_code = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_keypad_ui_if.sv
// Pixel, keypad-event and select signals between the LCD/keypad side and the renderer.
interface lcd_keypad_ui_if;
  import lcd_ui_pkg::*;

  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_start;
  logic        key_up;
  logic        key_down;
  logic        key_left;
  logic        key_right;
  logic        key_sel;
  rgb_t        pix_data;
  logic [1:0]  cursor_row;
  logic [1:0]  cursor_col;
  logic        sel_valid;
  logic [7:0]  sel_code;

  modport master (
    output pix_x, pix_y, frame_start, key_up, key_down, key_left, key_right, key_sel,
    input  pix_data, cursor_row, cursor_col, sel_valid, sel_code
  );

  modport slave (
    input  pix_x, pix_y, frame_start, key_up, key_down, key_left, key_right, key_sel,
    output pix_data, cursor_row, cursor_col, sel_valid, sel_code
  );
endinterface

// File: rtl/lcd_keypad_ui_font_rom.sv
// 8x8 glyph ROM for the keypad characters with a one-cycle registered read.
module font_rom (
  input  logic       clk,
  input  logic [7:0] char_code,
  input  logic [3:0] row,
  output logic [7:0] font_line
);
  logic [63:0] glyph;
  logic [2:0]  byte_sel;

  always_comb begin
    case (char_code)
      8'h30:   glyph = 64'h3C666E7666663C00;
      8'h31:   glyph = 64'h1838181818187E00;
      8'h32:   glyph = 64'h3C66060C30607E00;
      8'h33:   glyph = 64'h3C66061C06663C00;
      8'h34:   glyph = 64'h0C1C3C6C7E0C0C00;
      8'h35:   glyph = 64'h7E407C0202423C00;
      8'h36:   glyph = 64'h3C607C6666663C00;
      8'h37:   glyph = 64'h7E060C1830303000;
      8'h38:   glyph = 64'h3C66663C66663C00;
      8'h39:   glyph = 64'h3C66663E060C3800;
      8'h2B:   glyph = 64'h0018187E18180000;
      8'h3D:   glyph = 64'h00007E007E000000;
      default: glyph = 64'h0;
    endcase
  end

  // Glyph line 0 sits in the top byte.
  assign byte_sel = 3'd7 - row[2:0];

  // NOTE: the ROM read register has no reset; the renderer's pipeline valid flags mask it.
  always_ff @(posedge clk) begin
    font_line <= row[3] ? 8'h00 : glyph[{byte_sel, 3'b000} +: 8];
  end
endmodule

// File: rtl/lcd_keypad_ui.sv
// Keypad renderer: 2-stage pixel pipeline plus frame-synchronous cursor, select and flash state.
module lcd_keypad_ui
  import lcd_ui_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 3,
  parameter int BTN_W        = 60,
  parameter int BTN_H        = 60,
  parameter int GAP_X        = 20,
  parameter int GAP_Y        = 20,
  parameter int ORIGIN_X     = 100,
  parameter int ORIGIN_Y     = 150,
  parameter int BANNER_H     = 100,
  parameter int CUR_R0       = 1,
  parameter int CUR_C0       = 1,
  parameter int FLASH_FRAMES = 8
) (
  input logic             clk_in,
  input logic             sys_rst_n,
  lcd_keypad_ui_if.slave  bus
);
  localparam int          PITCH_X   = BTN_W + GAP_X;
  localparam int          PITCH_Y   = BTN_H + GAP_Y;
  localparam logic [11:0] GLYPH_LO  = 12'd18;
  localparam logic [11:0] GLYPH_HI  = 12'd34;
  localparam logic [1:0]  LAST_ROW  = 2'(ROWS - 1);
  localparam logic [1:0]  LAST_COL  = 2'(COLS - 1);

  // ---------------- stage 0: hit test and font address ----------------
  logic [11:0] px, py, off_x, off_y, edge_x, edge_y;
  logic        col_hit, row_hit, hit_c, glyph_c, banner_c;
  logic [1:0]  col_c, row_c;
  logic [7:0]  code_c;
  logic [2:0]  font_x_c, font_row_c;
  logic [7:0]  font_bits;

  assign px = {1'b0, bus.pix_x};
  assign py = {1'b0, bus.pix_y};

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    col_hit = 1'b0;
    col_c   = '0;
    off_x   = '0;
    edge_x  = '0;
    for (int c = 0; c < COLS; c++) begin
      edge_x = 12'(ORIGIN_X + c * PITCH_X);
      if (px >= edge_x && px < edge_x + 12'(BTN_W)) begin
        col_hit = 1'b1;
        col_c   = 2'(c);
        off_x   = px - edge_x;
      end
    end
  end

  always_comb begin
    row_hit = 1'b0;
    row_c   = '0;
    off_y   = '0;
    edge_y  = '0;
    for (int r = 0; r < ROWS; r++) begin
      edge_y = 12'(ORIGIN_Y + r * PITCH_Y);
      if (py >= edge_y && py < edge_y + 12'(BTN_H)) begin
        row_hit = 1'b1;
        row_c   = 2'(r);
        off_y   = py - edge_y;
      end
    end
  end

  assign hit_c      = col_hit & row_hit;
  assign code_c     = key_code(key_index(row_c, col_c, COLS));
  assign glyph_c    = hit_c && (code_c != 8'h00)
                      && off_x >= GLYPH_LO && off_x < GLYPH_HI
                      && off_y >= GLYPH_LO && off_y < GLYPH_HI;
  // 2x scaling: each font bit covers a 2x2 pixel block.
  assign font_x_c   = 3'((off_x - GLYPH_LO) >> 1);
  assign font_row_c = 3'((off_y - GLYPH_LO) >> 1);
  assign banner_c   = py < 12'(BANNER_H);

  font_rom u_font_rom (
    .clk       (clk_in),
    .char_code (code_c),
    .row       ({1'b0, font_row_c}),
    .font_line (font_bits)
  );

  // ---------------- stage 1: registered hit flags ----------------
  logic       s1_valid, s1_hit, s1_glyph, s1_banner;
  logic [1:0] s1_row, s1_col;
  logic [2:0] s1_font_x;

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      s1_glyph  <= 1'b0;
      s1_banner <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_font_x <= '0;
    end else begin
      s1_valid  <= 1'b1;
      s1_hit    <= hit_c;
      s1_glyph  <= glyph_c;
      s1_banner <= banner_c;
      s1_row    <= row_c;
      s1_col    <= col_c;
      s1_font_x <= font_x_c;
    end
  end

  // ---------------- cursor, select and flash state ----------------
  logic       nav_valid, any_dir;
  dir_e       nav_dir, dir_c;
  logic [1:0] cur_row, cur_col, nxt_row, nxt_col, flash_row, flash_col;
  logic [7:0] flash_cnt;
  logic       sel_valid_q;
  logic [7:0] sel_code_q;

  always_comb begin
    any_dir = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
    if (bus.key_up)        dir_c = DIR_UP;
    else if (bus.key_down) dir_c = DIR_DOWN;
    else if (bus.key_left) dir_c = DIR_LEFT;
    else                   dir_c = DIR_RIGHT;

    nxt_row = cur_row;
    nxt_col = cur_col;
    case (nav_dir)
      DIR_UP:    nxt_row = (cur_row == 2'd0)     ? LAST_ROW : cur_row - 2'd1;
      DIR_DOWN:  nxt_row = (cur_row == LAST_ROW) ? 2'd0     : cur_row + 2'd1;
      DIR_LEFT:  nxt_col = (cur_col == 2'd0)     ? LAST_COL : cur_col - 2'd1;
      DIR_RIGHT: nxt_col = (cur_col == LAST_COL) ? 2'd0     : cur_col + 2'd1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      nav_valid   <= 1'b0;
      nav_dir     <= DIR_UP;
      cur_row     <= 2'(CUR_R0);
      cur_col     <= 2'(CUR_C0);
      flash_cnt   <= '0;
      flash_row   <= '0;
      flash_col   <= '0;
      sel_valid_q <= 1'b0;
      sel_code_q  <= '0;
    end else begin
      // A pulse arriving with frame_start refills the latch for the following frame.
      if (bus.frame_start) begin
        if (nav_valid) begin
          cur_row <= nxt_row;
          cur_col <= nxt_col;
        end
        nav_valid <= any_dir;
        nav_dir   <= dir_c;
      end else if (!nav_valid && any_dir) begin
        nav_valid <= 1'b1;
        nav_dir   <= dir_c;
      end

      sel_valid_q <= bus.key_sel;
      if (bus.key_sel) begin
        sel_code_q <= key_code(key_index(cur_row, cur_col, COLS));
        flash_cnt  <= 8'(FLASH_FRAMES);
        flash_row  <= cur_row;
        flash_col  <= cur_col;
      end else if (bus.frame_start && flash_cnt != 8'd0) begin
        flash_cnt <= flash_cnt - 8'd1;
      end
    end
  end

  // ---------------- stage 2: colour select ----------------
  rgb_t colour, pix_q;

  always_comb begin
    colour = WHITE;
    if (!s1_valid)
      colour = BLACK;
    else if (s1_banner)
      colour = YELLOW;
    else if (s1_glyph && font_bits[3'd7 - s1_font_x])
      colour = BLACK;
    else if (s1_hit && flash_cnt != 8'd0 && s1_row == flash_row && s1_col == flash_col)
      colour = RED;
    else if (s1_hit && s1_row == cur_row && s1_col == cur_col)
      colour = ORANGE;
    else if (s1_hit)
      colour = GRAY;
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) pix_q <= BLACK;
    else            pix_q <= colour;
  end

  assign bus.pix_data   = pix_q;
  assign bus.cursor_row = cur_row;
  assign bus.cursor_col = cur_col;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.sel_code   = sel_code_q;
endmodule
